// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : CPU data-memory responder. Word RAM with byte/half/word access,
//             plus memory-mapped debug TX FIFO, STATUS, CYCLE and ERR regs.
//             Reads are combinational; writes land on the next rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
  parameter int N_WORDS    = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic        we,
  input  logic [2:0]  dt,
  output logic [31:0] rd,
  output logic [1:0]  err,
  output logic [31:0] dbg_data,
  output logic        dbg_valid,
  input  logic        dbg_ready
);

  // Access-type encoding (mem_dt_e)
  localparam logic [2:0] c_MEM_DT_BYTE  = 3'd0;
  localparam logic [2:0] c_MEM_DT_UBYTE = 3'd1;
  localparam logic [2:0] c_MEM_DT_HALF  = 3'd2;
  localparam logic [2:0] c_MEM_DT_UHALF = 3'd3;
  localparam logic [2:0] c_MEM_DT_WORD  = 3'd4;

  // Status encoding (errno_e)
  localparam logic [1:0] c_ENONE  = 2'd0;
  localparam logic [1:0] c_EALIGN = 2'd1;
  localparam logic [1:0] c_EADDR  = 2'd2;
  localparam logic [1:0] c_EFULL  = 2'd3;

  // Register window 0xFFFF_FF00..0xFFFF_FF0F, selected by addr[3:2]
  localparam logic [27:0] c_REG_WIN = 28'hFFFFFF0;
  localparam logic [1:0]  c_REG_TX  = 2'd0;
  localparam logic [1:0]  c_REG_ST  = 2'd1;
  localparam logic [1:0]  c_REG_CY  = 2'd2;
  localparam logic [1:0]  c_REG_ER  = 2'd3;

  localparam int          IDX_W       = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int          PTR_W       = $clog2(FIFO_DEPTH);
  localparam int          CNT_W       = PTR_W + 1;
  localparam logic [31:0] c_RAM_BYTES = 32'(N_WORDS * 4);
  localparam logic [CNT_W-1:0] c_FIFO_FULL = CNT_W'(FIFO_DEPTH);

  // Word RAM, intentionally left without reset so contents survive rst
  logic [31:0] mem [N_WORDS];

  logic [31:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0] r_cycle;
  logic [1:0]  r_err;

  logic        w_dt_byte;
  logic        w_dt_half;
  logic        w_dt_word;
  logic        w_dt_valid;
  logic        w_is_ram;
  logic        w_reg_win;
  logic        w_misalign;
  logic        w_full;
  logic        w_empty;
  logic [1:0]  w_err;
  logic [IDX_W-1:0] w_idx;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_cnt4;
  logic [31:0] w_rd_raw;
  logic        w_wr_ok;
  logic        w_push;
  logic        w_pop;
  logic        w_err_clr;
  logic        w_ram_we;

  assign w_dt_byte  = (dt == c_MEM_DT_BYTE) || (dt == c_MEM_DT_UBYTE);
  assign w_dt_half  = (dt == c_MEM_DT_HALF) || (dt == c_MEM_DT_UHALF);
  assign w_dt_word  = (dt == c_MEM_DT_WORD);
  assign w_dt_valid = w_dt_byte || w_dt_half || w_dt_word;

  assign w_is_ram  = (addr < c_RAM_BYTES);
  assign w_reg_win = (addr[31:4] == c_REG_WIN);

  // Undefined access types are treated as unaligned: no legal size exists.
  assign w_misalign = !w_dt_valid
                   || (w_dt_half && addr[0])
                   || (w_dt_word && (addr[1:0] != 2'b00))
                   || (w_reg_win && !w_dt_word);

  assign w_full  = (r_count == c_FIFO_FULL);
  assign w_empty = (r_count == '0);

  // Error classification: alignment beats decode, decode beats FIFO-full
  always_comb begin
    w_err = c_ENONE;
    if (w_misalign) begin
      w_err = c_EALIGN;
    end else if (!(w_is_ram || w_reg_win)) begin
      w_err = c_EADDR;
    end else if (w_reg_win && (addr[3:2] == c_REG_TX) && we && w_full) begin
      w_err = c_EFULL;
    end
  end

  assign w_idx  = addr[IDX_W+1:2];
  assign w_word = mem[w_idx];
  assign w_byte = w_word[{addr[1:0], 3'b000} +: 8];
  assign w_half = addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_cnt4 = 4'(r_count);

  // Read-data mux: RAM load formatting or register read-back
  always_comb begin
    w_rd_raw = 32'd0;
    if (w_is_ram) begin
      case (dt)
        c_MEM_DT_BYTE:  w_rd_raw = {{24{w_byte[7]}}, w_byte};
        c_MEM_DT_UBYTE: w_rd_raw = {24'd0, w_byte};
        c_MEM_DT_HALF:  w_rd_raw = {{16{w_half[15]}}, w_half};
        c_MEM_DT_UHALF: w_rd_raw = {16'd0, w_half};
        default:        w_rd_raw = w_word;
      endcase
    end else begin
      case (addr[3:2])
        c_REG_ST: w_rd_raw = {24'd0, w_cnt4, 2'b00, w_empty, w_full};
        c_REG_CY: w_rd_raw = r_cycle;
        c_REG_ER: w_rd_raw = {30'd0, r_err};
        default:  w_rd_raw = 32'd0;
      endcase
    end
  end

  assign rd  = (w_err == c_ENONE) ? w_rd_raw : 32'd0;
  assign err = w_err;

  // Only error-free writes may change state; EFULL blocks the push itself.
  assign w_wr_ok   = we && (w_err == c_ENONE);
  assign w_push    = w_wr_ok && w_reg_win && (addr[3:2] == c_REG_TX);
  assign w_err_clr = w_wr_ok && w_reg_win && (addr[3:2] == c_REG_ER);
  assign w_ram_we  = w_wr_ok && w_is_ram;
  assign w_pop     = !w_empty && dbg_ready;

  assign dbg_valid = !w_empty;
  assign dbg_data  = r_fifo[r_rptr];

  // RAM store: only the addressed lanes are written
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      if (w_dt_byte) begin
        mem[w_idx][{addr[1:0], 3'b000} +: 8] <= wd[7:0];
      end else if (w_dt_half) begin
        mem[w_idx][{addr[1], 4'b0000} +: 16] <= wd[15:0];
      end else begin
        mem[w_idx] <= wd;
      end
    end
  end

  // FIFO storage write; validity is governed solely by the pointers/count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= wd;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Free-running cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle <= 32'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  // Sticky error latch; a fresh error wins over a software clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= c_ENONE;
    end else if (w_err != c_ENONE) begin
      r_err <= w_err;
    end else if (w_err_clr) begin
      r_err <= c_ENONE;
    end
  end

endmodule
`default_nettype wire
